writeback_queue: RTL and testbench

Parametrised MEM→WB writeback stage for the multi-issue pipeline. It accepts up to `LANES` retiring results per cycle from memory stage lanes, aligns and sign/zero-extends load data, and drops non-writing results. Surviving results are buffered in program order in a `DEPTH`-entry queue, and up to `WR_PORTS` results per cycle drain to the register-file write ports. The register file may have fewer write ports than the issue width; the queue absorbs bursts and backpressures the memory stage.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_load_align.sv | 47 ++++
 rtl/writeback_queue.sv | 143 ++++++++++++++
 tb/tb_writeback_queue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared types and alignment constants for writeback_queue     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_pkg;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    localparam int WB_DATA_W_MAX = 64;
    localparam int WB_REG_AW_MAX = 8;

    typedef struct packed {
        logic [WB_REG_AW_MAX-1:0] addr;
        logic [WB_DATA_W_MAX-1:0] data;
    } wb_entry_t;

    // Granule sizes in bytes; masks clear the misaligned low offset bits.
    localparam int HALF_ALIGN = 2;
    localparam int WORD_ALIGN = 4;

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_load_align : selects the addressed load granule and extends it     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  ld_size_e          size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [OFF_W-1:0]  HALF_MASK = ~OFF_W'(HALF_ALIGN - 1);
    localparam logic [OFF_W-1:0]  WORD_MASK = ~OFF_W'(WORD_ALIGN - 1);
    localparam logic [DATA_W-1:0] B_KEEP    = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] H_KEEP    = DATA_W'(16'hFFFF);
    localparam logic [DATA_W-1:0] W_KEEP    = DATA_W'(32'hFFFF_FFFF);

    logic [DATA_W-1:0] w_sh_b, w_sh_h, w_sh_w, w_sel, w_keep, w_ext;
    logic              w_sign;

    // Keep mask selects the granule bits; everything above is the extension.
    always_comb begin
        w_sh_b = rdata_i >> {offset_i, 3'b000};
        w_sh_h = rdata_i >> {offset_i & HALF_MASK, 3'b000};
        w_sh_w = rdata_i >> {offset_i & WORD_MASK, 3'b000};
        w_sel  = rdata_i;
        w_keep = '1;
        w_sign = 1'b0;
        case (size_i)
            LD_B: begin w_sel = w_sh_b; w_keep = B_KEEP; w_sign = w_sh_b[7];  end
            LD_H: begin w_sel = w_sh_h; w_keep = H_KEEP; w_sign = w_sh_h[15]; end
            LD_W: begin w_sel = w_sh_w; w_keep = W_KEEP; w_sign = w_sh_w[31]; end
            default: ;
        endcase
        w_ext  = {DATA_W{w_sign & ~unsigned_i}};
        data_o = (w_sel & w_keep) | (w_ext & ~w_keep);
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_queue : MEM->WB stage, in-order queue draining to RF ports  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module writeback_queue
    import wb_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int WR_PORTS = 1,
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0]             in_reg_write,
    input  logic [LANES-1:0]             in_mem_to_reg,
    input  logic [2*LANES-1:0]           in_ld_size,
    input  logic [LANES-1:0]             in_ld_unsigned,
    input  logic [DATA_W*LANES-1:0]      in_alu_out,
    input  logic [DATA_W*LANES-1:0]      in_read_data,
    input  logic [REG_AW*LANES-1:0]      in_write_reg,
    output logic [WR_PORTS-1:0]          wr_en,
    output logic [REG_AW*WR_PORTS-1:0]   wr_addr,
    output logic [DATA_W*WR_PORTS-1:0]   wr_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [CNT_W-1:0] C_LANES = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_PORTS = CNT_W'(WR_PORTS);

    logic [REG_AW-1:0]          mem_addr_q [DEPTH];
    logic [DATA_W-1:0]          mem_data_q [DEPTH];
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d, push_cnt, pop_cnt;
    logic [WR_PORTS-1:0]        wr_en_q, wr_en_d;
    logic [REG_AW*WR_PORTS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W*WR_PORTS-1:0] wr_data_q, wr_data_d;

    logic [LANES-1:0]  w_keep;
    logic [DATA_W-1:0] w_ld_data [LANES];
    logic [DATA_W-1:0] w_result  [LANES];
    logic [DEPTH-1:0]  w_slot_we;
    logic [REG_AW-1:0] w_slot_addr [DEPTH];
    logic [DATA_W-1:0] w_slot_data [DEPTH];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        wb_load_align #(.DATA_W(DATA_W)) u_align (
            .rdata_i    (in_read_data[l*DATA_W +: DATA_W]),
            .offset_i   (in_alu_out[l*DATA_W +: OFF_W]),
            .size_i     (ld_size_e'(in_ld_size[2*l +: 2])),
            .unsigned_i (in_ld_unsigned[l]),
            .data_o     (w_ld_data[l])
        );
        assign w_keep[l]   = in_valid[l] & in_reg_write[l] & (in_write_reg[l*REG_AW +: REG_AW] != '0);
        assign w_result[l] = in_mem_to_reg[l] ? w_ld_data[l] : in_alu_out[l*DATA_W +: DATA_W];
    end

    // Space for a full lane group is required; this cycle's pops are not credited.
    assign in_ready = (C_DEPTH - count_q) >= C_LANES;

    always_comb begin
        logic [PTR_W-1:0] slot;
        slot      = '0;
        push_cnt  = '0;
        w_slot_we = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_slot_addr[s] = '0;
            w_slot_data[s] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (in_ready && w_keep[l]) begin
                slot              = tail_q + PTR_W'(push_cnt);
                w_slot_we[slot]   = 1'b1;
                w_slot_addr[slot] = in_write_reg[l*REG_AW +: REG_AW];
                w_slot_data[slot] = w_result[l];
                push_cnt          = push_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] rd;
        rd        = '0;
        pop_cnt   = (count_q < C_PORTS) ? count_q : C_PORTS;
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (CNT_W'(p) < pop_cnt) begin
                rd                                = head_q + PTR_W'(p);
                wr_en_d[p]                        = 1'b1;
                wr_addr_d[p*REG_AW +: REG_AW]     = mem_addr_q[rd];
                wr_data_d[p*DATA_W +: DATA_W]     = mem_data_q[rd];
            end
        end
        head_d  = head_q + PTR_W'(pop_cnt);
        tail_d  = tail_q + PTR_W'(push_cnt);
        count_d = count_q + push_cnt - pop_cnt;
    end

    // Entry storage carries no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (w_slot_we[s]) begin
                mem_addr_q[s] <= w_slot_addr[s];
                mem_data_q[s] <= w_slot_data[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_writeback_queue : directed self-checking bench for writeback_queue |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_writeback_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Instance A: LANES=2, WR_PORTS=1, DATA_W=32, DEPTH=4
    logic [1:0]  a_valid, a_rw, a_m2r, a_uns;
    logic [3:0]  a_size;
    logic [63:0] a_alu, a_rd;
    logic [9:0]  a_wreg;
    logic        a_ready;
    logic [0:0]  a_wr_en;
    logic [4:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [2:0]  a_count;

    // Instance B: LANES=2, WR_PORTS=2, DATA_W=64, DEPTH=4
    logic [1:0]   b_valid, b_rw, b_m2r, b_uns;
    logic [3:0]   b_size;
    logic [127:0] b_alu, b_rd;
    logic [9:0]   b_wreg;
    logic         b_ready;
    logic [1:0]   b_wr_en;
    logic [9:0]   b_wr_addr;
    logic [127:0] b_wr_data;
    logic [2:0]   b_count;

    int checks = 0;
    int passes = 0;

    writeback_queue #(.LANES(2), .WR_PORTS(1), .DATA_W(32), .REG_AW(5), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_reg_write(a_rw), .in_mem_to_reg(a_m2r), .in_ld_size(a_size),
        .in_ld_unsigned(a_uns), .in_alu_out(a_alu), .in_read_data(a_rd),
        .in_write_reg(a_wreg), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .count(a_count)
    );

    writeback_queue #(.LANES(2), .WR_PORTS(2), .DATA_W(64), .REG_AW(5), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_reg_write(b_rw), .in_mem_to_reg(b_m2r), .in_ld_size(b_size),
        .in_ld_unsigned(b_uns), .in_alu_out(b_alu), .in_read_data(b_rd),
        .in_write_reg(b_wreg), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .count(b_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a;
        a_valid = '0; a_rw = '0; a_m2r = '0; a_uns = '0;
        a_size = '0; a_alu = '0; a_rd = '0; a_wreg = '0;
    endtask

    task automatic clear_b;
        b_valid = '0; b_rw = '0; b_m2r = '0; b_uns = '0;
        b_size = '0; b_alu = '0; b_rd = '0; b_wreg = '0;
    endtask

    task automatic drive_load_a(input logic [1:0] size, input logic uns, input logic [31:0] alu,
                                input logic [31:0] rd, input logic [4:0] rg);
        clear_a;
        a_valid = 2'b01; a_rw = 2'b01; a_m2r = 2'b01;
        a_size = {2'b00, size}; a_uns = {1'b0, uns};
        a_alu = {32'h0, alu}; a_rd = {32'h0, rd}; a_wreg = {5'd0, rg};
    endtask

    task automatic drive_pair_a(input int k);
        a_valid = 2'b11; a_rw = 2'b11; a_m2r = 2'b00; a_uns = 2'b00; a_size = '0; a_rd = '0;
        a_wreg = {5'(2*k + 2), 5'(2*k + 1)};
        a_alu  = {32'((2*k + 2) * 32'h11), 32'((2*k + 1) * 32'h11)};
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_a;
        clear_b;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_count, a_wr_en, a_wr_addr, a_wr_data, a_ready} !== {3'd0, 1'b0, 5'd0, 32'd0, 1'b1})
            $display("FAIL reset_a: cnt=%0d en=%b addr=%0d data=%h rdy=%b, want 0/0/0/0/1",
                     a_count, a_wr_en, a_wr_addr, a_wr_data, a_ready);
        else passes++;
        checks++;
        if ({b_count, b_wr_en, b_ready} !== {3'd0, 2'b00, 1'b1})
            $display("FAIL reset_b: cnt=%0d en=%b rdy=%b, want 0/00/1", b_count, b_wr_en, b_ready);
        else passes++;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_load_ext;
        logic [31:0] exp_s [4];
        logic [31:0] exp_u [4];
        logic [31:0] exp;
        exp_s = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
        exp_u = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
        for (int u = 0; u < 2; u++) begin
            for (int o = 0; o < 4; o++) begin
                drive_load_a(2'd0, u[0], 32'(o), 32'h80FF_7F01, 5'd1);
                tick;
                clear_a;
                tick;
                exp = (u == 0) ? exp_s[o] : exp_u[o];
                checks++;
                if ({a_wr_en, a_wr_data} !== {1'b1, exp})
                    $display("FAIL load_byte u=%0d off=%0d: en=%b data=%h, want en=1 data=%h",
                             u, o, a_wr_en, a_wr_data, exp);
                else passes++;
            end
        end
        // Half at offset 3: low bit ignored, bytes 2..3 = 0x80FF
        drive_load_a(2'd1, 1'b0, 32'd3, 32'h80FF_7F01, 5'd2);
        tick; clear_a; tick;
        checks++;
        if ({a_wr_en, a_wr_data} !== {1'b1, 32'hFFFF_80FF})
            $display("FAIL load_half_signed: en=%b data=%h, want 1 ffff80ff", a_wr_en, a_wr_data);
        else passes++;
        drive_load_a(2'd1, 1'b1, 32'd1, 32'h80FF_7F01, 5'd2);
        tick; clear_a; tick;
        checks++;
        if ({a_wr_en, a_wr_data} !== {1'b1, 32'h0000_7F01})
            $display("FAIL load_half_unsigned: en=%b data=%h, want 1 00007f01", a_wr_en, a_wr_data);
        else passes++;
        tick;
    endtask

    task automatic test_drop;
        clear_a;
        a_valid = 2'b11; a_rw = 2'b01; a_wreg = {5'd7, 5'd0}; a_alu = {32'h55, 32'h66};
        tick;
        checks++;
        if (a_count !== 3'd0) $display("FAIL drop_count: count=%0d, want 0", a_count);
        else passes++;
        clear_a;
        tick;
        checks++;
        if ({a_wr_en, a_count} !== {1'b0, 3'd0})
            $display("FAIL drop_wr_en: en=%b count=%0d, want 0/0", a_wr_en, a_count);
        else passes++;
    endtask

    task automatic test_latency;
        clear_a;
        a_valid = 2'b01; a_rw = 2'b01; a_alu = {32'h0, 32'hDEAD_BEEF}; a_wreg = {5'd0, 5'd3};
        tick;
        checks++;
        if ({a_count, a_wr_en} !== {3'd1, 1'b0})
            $display("FAIL latency_edgeN: count=%0d en=%b, want 1/0", a_count, a_wr_en);
        else passes++;
        clear_a;
        tick;
        checks++;
        if ({a_wr_en, a_wr_addr, a_wr_data} !== {1'b1, 5'd3, 32'hDEAD_BEEF})
            $display("FAIL latency_edgeN1: en=%b addr=%0d data=%h, want 1/3/deadbeef",
                     a_wr_en, a_wr_addr, a_wr_data);
        else passes++;
        tick;
        checks++;
        if ({a_wr_en, a_wr_addr, a_wr_data} !== {1'b0, 5'd0, 32'd0})
            $display("FAIL latency_edgeN2: en=%b addr=%0d data=%h, want 0/0/0",
                     a_wr_en, a_wr_addr, a_wr_data);
        else passes++;
    endtask

    task automatic test_backpressure;
        int pair, cnt_m, n_got, popped;
        logic acc, rdy_m;
        logic [4:0]  got_a [8];
        logic [31:0] got_d [8];
        pair = 0; cnt_m = 0; n_got = 0;
        for (int i = 0; i < 8; i++) begin got_a[i] = '0; got_d[i] = '0; end
        drive_pair_a(0);
        for (int cyc = 0; cyc < 40 && n_got < 8; cyc++) begin
            rdy_m = (cnt_m <= 2);
            checks++;
            if (a_ready !== rdy_m)
                $display("FAIL bp_ready cyc=%0d: ready=%b, want %b (model count %0d)", cyc, a_ready, rdy_m, cnt_m);
            else passes++;
            acc = rdy_m && (pair < 4);
            tick;
            popped = (cnt_m > 0) ? 1 : 0;
            cnt_m  = cnt_m + (acc ? 2 : 0) - popped;
            checks++;
            if (a_count !== 3'(cnt_m))
                $display("FAIL bp_count cyc=%0d: count=%0d, want %0d", cyc, a_count, cnt_m);
            else passes++;
            if (a_wr_en[0] === 1'b1) begin
                if (n_got < 8) begin
                    got_a[n_got] = a_wr_addr;
                    got_d[n_got] = a_wr_data;
                end
                n_got++;
            end
            if (acc) begin
                pair++;
                if (pair < 4) drive_pair_a(pair);
                else clear_a;
            end
        end
        checks++;
        if (n_got !== 8) $display("FAIL bp_total: writes=%0d, want 8 within budget", n_got);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({got_a[i], got_d[i]} !== {5'(i + 1), 32'((i + 1) * 32'h11)})
                $display("FAIL bp_order[%0d]: addr=%0d data=%h, want %0d %h",
                         i, got_a[i], got_d[i], i + 1, (i + 1) * 32'h11);
            else passes++;
        end
        clear_a;
        tick;
        checks++;
        if ({a_count, a_wr_en} !== {3'd0, 1'b0})
            $display("FAIL bp_drained: count=%0d en=%b, want 0/0", a_count, a_wr_en);
        else passes++;
    endtask

    task automatic test_conflict;
        clear_b;
        b_valid = 2'b11; b_rw = 2'b11; b_wreg = {5'd5, 5'd5};
        b_alu = {64'h22, 64'h11};
        tick;
        clear_b;
        tick;
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data} !== {2'b11, 5'd5, 5'd5, 64'h22, 64'h11})
            $display("FAIL conflict: en=%b addr=%h data=%h, want 11 r5/r5 p0=11 p1=22",
                     b_wr_en, b_wr_addr, b_wr_data);
        else passes++;
        tick;
    endtask

    task automatic test_wide_loads;
        clear_b;
        b_valid = 2'b11; b_rw = 2'b11; b_m2r = 2'b11;
        b_size = {2'd3, 2'd2}; b_uns = 2'b10;
        b_alu  = {64'd0, 64'd6};
        b_rd   = {64'h0123_4567_89AB_CDEF, 64'h8000_0000_1234_5678};
        b_wreg = {5'd10, 5'd9};
        tick;
        clear_b;
        tick;
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data} !==
            {2'b11, 5'd10, 5'd9, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_8000_0000})
            $display("FAIL wide_loads: en=%b addr=%h data=%h, want 11 r10/r9 0123456789abcdef/ffffffff80000000",
                     b_wr_en, b_wr_addr, b_wr_data);
        else passes++;
        tick;
    endtask

    task automatic test_reset_mid_drain;
        drive_pair_a(0);
        tick;
        drive_pair_a(1);
        tick;
        clear_a;
        checks++;
        if ({a_count, a_wr_en} !== {3'd3, 1'b1})
            $display("FAIL rst_setup: count=%0d en=%b, want 3/1", a_count, a_wr_en);
        else passes++;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({a_count, a_wr_en, a_wr_addr, a_wr_data, a_ready} !== {3'd0, 1'b0, 5'd0, 32'd0, 1'b1})
            $display("FAIL rst_async: cnt=%0d en=%b addr=%0d data=%h rdy=%b, want 0/0/0/0/1",
                     a_count, a_wr_en, a_wr_addr, a_wr_data, a_ready);
        else passes++;
        #2 rst = 1'b1;
        tick;
        checks++;
        if ({a_count, a_wr_en} !== {3'd0, 1'b0})
            $display("FAIL rst_release: count=%0d en=%b, want 0/0", a_count, a_wr_en);
        else passes++;
    endtask

    initial begin
        test_reset;
        test_load_ext;
        test_drop;
        test_latency;
        test_backpressure;
        test_conflict;
        test_wide_loads;
        test_reset_mid_drain;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
